// File: rtl/spi_master_gen.sv
`default_nettype none
// spi_master_gen: SPI master with one-hot chip select and per-frame CPOL/CPHA. Rev 1.0
// Optional macro SPI_MASTER_LOOPBACK_EN feeds the receive shifter from internal mosi.
module spi_master_gen #(
  parameter int DATA_W    = 12,
  parameter int N_SLAVES  = 4,
  parameter int CLK_DIV   = 6,
  parameter int LSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   din,
  input  logic [N_SLAVES-1:0] slave_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                miso,
  output logic                sclk,
  output logic                mosi,
  output logic [N_SLAVES-1:0] cs_n,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   dout,
  output logic                err
);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2 * DATA_W);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state_q;
  logic [DIV_W-1:0]      div_cnt_q;
  logic [EDGE_W-1:0]     edge_cnt_q;
  logic                  sclk_q, mosi_q, busy_q, done_q, err_q, cpol_q, cpha_q;
  logic [N_SLAVES-1:0]   cs_n_q;
  logic [DATA_W-1:0]     tx_q, rx_q, dout_q;

  logic sel_onehot_d, div_tick_d, leading_d, last_edge_d, rx_in_d;

  function automatic logic tx_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign sel_onehot_d = (slave_sel != '0) &&
                        ((slave_sel & (slave_sel - N_SLAVES'(1))) == '0);
  assign div_tick_d   = (div_cnt_q == DIV_LAST);
  // Edge counter is zero-based, so even values are leading edges.
  assign leading_d    = ~edge_cnt_q[0];
  assign last_edge_d  = (edge_cnt_q == EDGE_LAST);

`ifdef SPI_MASTER_LOOPBACK_EN
  // miso stays in the expression only so the port remains referenced; it never affects rx.
  assign rx_in_d = mosi_q | (miso & 1'b0);
`else
  assign rx_in_d = miso;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cs_n_q     <= '1;
      tx_q       <= '0;
      rx_q       <= '0;
      dout_q     <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && sel_onehot_d) begin
            state_q    <= SETUP;
            busy_q     <= 1'b1;
            cs_n_q     <= ~slave_sel;
            cpol_q     <= cpol;
            cpha_q     <= cpha;
            sclk_q     <= cpol;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            rx_q       <= '0;
            // CPHA=0 presents the first bit before any sclk edge; CPHA=1 waits for the leading edge.
            if (cpha) begin
              mosi_q <= 1'b0;
              tx_q   <= din;
            end else begin
              mosi_q <= tx_bit(din);
              tx_q   <= tx_shift(din);
            end
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        SETUP: begin
          if (div_tick_d) begin
            state_q   <= XFER;
            div_cnt_q <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        XFER: begin
          if (div_tick_d) begin
            div_cnt_q  <= '0;
            sclk_q     <= ~sclk_q;
            edge_cnt_q <= last_edge_d ? '0 : edge_cnt_q + EDGE_W'(1);
            if (leading_d == ~cpha_q) begin
              rx_q <= rx_shift(rx_q, rx_in_d);
            end else if (cpha_q || !last_edge_d) begin
              mosi_q <= tx_bit(tx_q);
              tx_q   <= tx_shift(tx_q);
            end
            if (last_edge_d) state_q <= HOLD;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        HOLD: begin
          if (div_tick_d) begin
            state_q   <= IDLE;
            div_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            cs_n_q    <= '1;
            mosi_q    <= 1'b0;
            dout_q    <= rx_q;
          end else begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Idle sclk tracks the live cpol input, but reset must still force it low.
  assign sclk = (state_q == IDLE) ? (cpol & rst_n) : sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_gen.sv
`default_nettype none
// tb_spi_master_gen: table-driven frames against a behavioural SPI slave, plus
// hand-written re-pulse, abort-by-reset and restart sequences.
`timescale 1ns/1ps
module tb_spi_master_gen;
  localparam int DW = 12;
  localparam int NS = 4;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpol = 1'b0;
  logic cpha = 1'b0;
  logic [DW-1:0] din = '0;
  logic [NS-1:0] slave_sel = '0;
  logic miso;
  logic sclk, mosi, busy, done, err;
  logic [NS-1:0] cs_n;
  logic [DW-1:0] dout;

  int n_checks = 0;
  int n_errors = 0;

  spi_master_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .slave_sel(slave_sel),
    .cpol(cpol), .cpha(cpha), .miso(miso), .sclk(sclk), .mosi(mosi),
    .cs_n(cs_n), .busy(busy), .done(done), .dout(dout), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural slave: shifts slv_word out LSB first, captures mosi on its sample edge.
  logic [DW-1:0] slv_word = '0;
  logic [DW-1:0] cap_word = '0;
  int  sidx = 0;
  int  ncap = 0;
  int  frame_id = 0;
  int  seen_id = 0;
  bit  in_frame = 1'b0;
  bit  f_cpol = 1'b0;
  bit  f_cpha = 1'b0;

  always @(sclk or frame_id) begin
    if (frame_id != seen_id) begin
      seen_id  = frame_id;
      sidx     = 0;
      ncap     = 0;
      cap_word = '0;
    end else if (in_frame) begin
      if ((sclk != f_cpol) == !f_cpha) begin
        if (ncap < DW) cap_word[ncap] = mosi;
        ncap++;
      end else begin
        sidx++;
      end
    end
  end

  always_comb begin
    miso = 1'b0;
    if (!LB && in_frame) begin
      if (!f_cpha) begin
        if (sidx < DW) miso = slv_word[sidx];
      end else if (sidx >= 1 && sidx <= DW) begin
        miso = slv_word[sidx-1];
      end
    end
  end

  typedef struct {
    logic          cpol;
    logic          cpha;
    logic [DW-1:0] din;
    logic [NS-1:0] sel;
    logic [DW-1:0] slv;
    logic [NS-1:0] exp_cs;
    bit            exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input vec_t v, input int repulse_at, input int abort_at);
    int cyc;
    int bad;
    bit seen;
    logic [DW-1:0] exp_dout;
    exp_dout = LB ? v.din : v.slv;
    cpol = v.cpol; cpha = v.cpha; din = v.din; slave_sel = v.sel;
    f_cpol = v.cpol; f_cpha = v.cpha; slv_word = v.slv;
    frame_id++;
    start = 1'b1;
    #1;
    chk("idle_sclk_live", 32'(sclk), 32'(v.cpol));
    chk("idle_cs_n", 32'(cs_n), 32'hF);
    @(posedge clk); #1;
    start = 1'b0;
    if (v.exp_err) begin
      chk("err_pulse", 32'(err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_cs_n", 32'(cs_n), 32'hF);
      @(posedge clk); #1;
      chk("err_one_cycle", 32'(err), 32'd0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        if (sclk !== v.cpol || cs_n !== 4'hF || busy !== 1'b0 || done !== 1'b0) bad++;
        @(posedge clk); #1;
      end
      chk("err_no_activity", 32'(bad), 32'd0);
      return;
    end
    in_frame = 1'b1;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("cs_n_selected", 32'(cs_n), 32'(v.exp_cs));
    chk("setup_sclk_idle", 32'(sclk), 32'(v.cpol));
    din = ~v.din; slave_sel = ~v.sel; cpha = ~v.cpha;
    seen = 1'b0;
    cyc = 0;
    while (cyc < 400 && !seen) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        in_frame = 1'b0;
        chk("abort_cs_n", 32'(cs_n), 32'hF);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_dout", 32'(dout), 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          if (done !== 1'b0) bad++;
        end
        chk("abort_no_done", 32'(bad), 32'd0);
        return;
      end
      if (cyc == repulse_at) begin
        start = 1'b1; slave_sel = v.sel;
      end
      if (cyc == repulse_at + 1) begin
        start = 1'b0; slave_sel = ~v.sel;
        chk("repulse_no_err", 32'(err), 32'd0);
      end
      if (done === 1'b1) seen = 1'b1;
    end
    in_frame = 1'b0;
    chk("done_cycle", 32'(cyc), 32'd156);
    chk("done_dout", 32'(dout), 32'(exp_dout));
    chk("done_cs_n", 32'(cs_n), 32'hF);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_mosi_zero", 32'(mosi), 32'd0);
    chk("mosi_bits", 32'(cap_word), 32'(v.din));
    chk("sclk_sample_edges", 32'(ncap), 32'd12);
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 12'hA5C, 4'b0001, 12'h3C9, 4'b1110, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 12'h123, 4'b0100, 12'h3C9, 4'b1011, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 12'h000, 4'b0110, 12'h000, 4'b1111, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 12'hFFF, 4'b1000, 12'h000, 4'b0111, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 12'h0F0, 4'b0000, 12'h000, 4'b1111, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 12'h801, 4'b0010, 12'h7FE, 4'b1101, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 12'h0F0, 4'b1111, 12'h000, 4'b1111, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 12'h5A3, 4'b0001, 12'h0F0, 4'b1110, 1'b0};

    cpol = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_cs_n", 32'(cs_n), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rst_n = 1'b1;

    // Successive calls start in the cycle right after the previous done.
    for (int i = 0; i < 8; i++) run_frame(tbl[i], -1, -1);

    run_frame(tbl[0], 50, -1);
    @(posedge clk); #1;
    chk("done_single_pulse", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_queued_frame", 32'(busy), 32'd0);
    chk("no_queued_cs_n", 32'(cs_n), 32'hF);

    run_frame(tbl[1], -1, 80);
    rst_n = 1'b1;
    run_frame(tbl[5], -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_master_gen.md
SPI_MASTER_GEN -- requirements
Module: spi_master_gen

Interface
REQ-001 Parameter DATA_W, default 12, frame length in bits (>=2).
REQ-002 Parameter N_SLAVES, default 4, number of chip-select lines (>=1).
REQ-003 Parameter CLK_DIV, default 6, sclk half-period in clk cycles (>=2).
REQ-004 Parameter LSB_FIRST, default 1; 1 = bit 0 shifted first, 0 = bit DATA_W-1 shifted first.
REQ-005 clk  input  1  system clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start  input  1  transfer request, sampled in IDLE only.
REQ-008 din  input  DATA_W  transmit word, latched on accept.
REQ-009 slave_sel  input  N_SLAVES  one-hot target select, latched on accept.
REQ-010 cpol  input  1  clock polarity, latched on accept.
REQ-011 cpha  input  1  clock phase, latched on accept.
REQ-012 miso  input  1  serial receive data.
REQ-013 sclk  output  1  SPI serial clock.
REQ-014 mosi  output  1  serial transmit data.
REQ-015 cs_n  output  N_SLAVES  active-low chip selects.
REQ-016 busy  output  1  high from accept until done.
REQ-017 done  output  1  one-cycle completion pulse.
REQ-018 dout  output  DATA_W  received word, valid from done until next done.
REQ-019 err  output  1  one-cycle pulse, rejected request.

Function
REQ-020 FSM states IDLE, SETUP, XFER, HOLD; IDLE->SETUP on valid accept, SETUP->XFER after CLK_DIV cycles, XFER->HOLD after 2*DATA_W sclk edges, HOLD->IDLE after CLK_DIV cycles.
REQ-021 Accept = start high in IDLE with slave_sel exactly one-hot; zero or multi-hot select pulses err for one cycle, FSM stays IDLE, cs_n stays all-ones.
REQ-022 start while busy is ignored; no queuing.
REQ-023 In IDLE sclk equals live cpol; from accept to HOLD exit sclk idle level is latched cpol; sclk toggles only in XFER, every CLK_DIV cycles.
REQ-024 cs_n bit of selected slave low from SETUP entry through HOLD exit; all other bits high throughout.
REQ-025 cpha=0: first bit on mosi at SETUP entry; miso sampled on each leading edge; mosi advances on each trailing edge except the last.
REQ-026 cpha=1: mosi advances on each leading edge; miso sampled on each trailing edge.
REQ-027 Receive bit order equals transmit bit order (LSB_FIRST).
REQ-028 done pulses exactly (2*DATA_W+2)*CLK_DIV cycles after accept cycle; same cycle cs_n returns all-ones, busy falls, dout updates.
REQ-029 mosi = 0 outside SETUP/XFER/HOLD.
REQ-030 Back-to-back: start high in cycle after done is accepted; cs_n high at least one cycle between frames.
REQ-031 Changes to din, slave_sel, cpol, cpha while busy have no effect on the current frame.

Reset
REQ-032 rst_n low forces immediately: FSM IDLE, sclk 0, mosi 0, cs_n all-ones, busy 0, done 0, err 0, dout 0, internal counters 0.
REQ-033 Reset mid-transfer aborts the frame with no done pulse; dout 0.
REQ-034 First accept possible the first clk edge after rst_n release.

Configuration
REQ-035 Macro SPI_MASTER_LOOPBACK_EN defined: receive shifter samples internal mosi instead of miso pin, so dout equals din of the frame; miso ignored.
REQ-036 Macro undefined: receive shifter samples miso per REQ-025/026; no loopback logic present.

Verification
REQ-037 Defaults, cpol=0 cpha=0, din=12'hA5C, slave_sel=4'b0001 -> cs_n=4'b1110, mosi on rising edges 0,0,1,1,1,0,1,0,0,1,0,1, done at cycle 156 after accept.
REQ-038 cpol=1 cpha=1, slave model returns 12'h3C9 on slave_sel=4'b0100 -> sclk idles high, cs_n=4'b1011, dout=12'h3C9 at done.
REQ-039 slave_sel=4'b0110 with start -> err high one cycle, busy 0, cs_n=4'b1111, no sclk activity.
REQ-040 start re-pulsed at cycle 50 of a frame -> ignored, exactly one done, next frame only on new start after done.
REQ-041 rst_n low at cycle 80 of a frame -> cs_n=4'b1111 and sclk=0 before next clk edge, no done, dout=0.
REQ-042 SPI_MASTER_LOOPBACK_EN defined, miso held 0, din=12'h5A3 -> dout=12'h5A3.
